// File: rtl/serial_adder_seq_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: state encoding
// constants and the FSM state type built on them.
package serial_adder_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_adder_seq_cell.sv
// One-bit full adder built from two half adders whose carries are ORed.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic ha1_sum;
    logic ha1_carry;
    logic ha2_carry;

    assign ha1_sum   = a ^ b;
    assign ha1_carry = a & b;
    assign sum       = ha1_sum ^ cin;
    assign ha2_carry = ha1_sum & cin;
    assign cout      = ha1_carry | ha2_carry;

endmodule

// File: rtl/serial_adder_seq.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, LSB first, with a
// start/busy/done handshake. Result and flags hold until the next accepted start.
module serial_adder_seq
    import serial_adder_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG) + 1;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             run_c;
    logic [DIGIT:0]   c_chain;
    logic [DIGIT-1:0] slice_sum;
    logic             last_slice;

    // Ripple chain for the current digit; the shift registers present the
    // next DIGIT operand bits at their low end each cycle.
    assign c_chain[0] = run_c;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        full_adder_cell u_fa (
            .a    (a_sh[i]),
            .b    (b_sh[i]),
            .cin  (c_chain[i]),
            .sum  (slice_sum[i]),
            .cout (c_chain[i+1])
        );
    end

    assign last_slice = (cnt == CW'(NDIG - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            run_c    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    // Subtraction is A + ~B + 1, so sub doubles as the initial carry.
                    if (start) begin
                        a_sh     <= a;
                        b_sh     <= sub ? ~b : b;
                        run_c    <= sub;
                        cnt      <= '0;
                        sum      <= '0;
                        carry    <= 1'b0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NDIG; k++) begin
                        if (cnt == CW'(k)) begin
                            sum[k*DIGIT +: DIGIT] <= slice_sum;
                        end
                    end
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    run_c <= c_chain[DIGIT];
                    if (last_slice) begin
                        carry    <= c_chain[DIGIT];
                        overflow <= c_chain[DIGIT] ^ c_chain[DIGIT-1];
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench: three configurations of serial_adder_seq compared
// against an arithmetic reference model of add/subtract with carry and overflow.
module tb_serial_adder_seq;

    logic clk;
    logic rst;

    logic       s4, sub4, busy4, done4, c4, ov4;
    logic [3:0] a4, b4, sum4;

    logic       s8, sub8, busy8, done8, c8, ov8;
    logic [7:0] a8, b8, sum8;

    logic        s16, sub16, busy16, done16, c16, ov16;
    logic [15:0] a16, b16, sum16;

    int checks;
    int failures;

    serial_adder_seq #(.WIDTH(4), .DIGIT(1)) dut4 (
        .clk(clk), .rst(rst), .start(s4), .a(a4), .b(b4), .sub(sub4),
        .busy(busy4), .done(done4), .sum(sum4), .carry(c4), .overflow(ov4)
    );

    serial_adder_seq #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .sub(sub8),
        .busy(busy8), .done(done8), .sum(sum8), .carry(c8), .overflow(ov8)
    );

    serial_adder_seq #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .start(s16), .a(a16), .b(b16), .sub(sub16),
        .busy(busy16), .done(done16), .sum(sum16), .carry(c16), .overflow(ov16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: unsigned result modulo 2^w, carry as unsigned overflow or
    // no-borrow, overflow as signed result outside the w-bit range.
    function automatic void ref_op(input int w, input longint ua, input longint ub, input bit s,
                                   output longint rs, output bit rc, output bit rov);
        longint m, sa, sb, sr;
        m = longint'(1) << w;
        if (s) begin
            rs = (ua - ub + m) % m;
            rc = (ua >= ub);
        end else begin
            rs = (ua + ub) % m;
            rc = ((ua + ub) >= m);
        end
        sa  = (ua >= m / 2) ? ua - m : ua;
        sb  = (ub >= m / 2) ? ub - m : ub;
        sr  = s ? sa - sb : sa + sb;
        rov = (sr < -(m / 2)) || (sr >= m / 2);
    endfunction

    // The op tasks are entered #1 after an edge; lat counts edges from the
    // start being driven until done is seen, or stays -1 on timeout.
    task automatic op4(input logic [3:0] ia, input logic [3:0] ib, input logic is,
                       output logic [3:0] rs, output logic rc, output logic rov, output int lat);
        a4 = ia; b4 = ib; sub4 = is; s4 = 1'b1;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            s4 = 1'b0;
            if (done4) begin lat = n; break; end
        end
        rs = sum4; rc = c4; rov = ov4;
    endtask

    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic is,
                       output logic [7:0] rs, output logic rc, output logic rov, output int lat);
        a8 = ia; b8 = ib; sub8 = is; s8 = 1'b1;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            s8 = 1'b0;
            if (done8) begin lat = n; break; end
        end
        rs = sum8; rc = c8; rov = ov8;
    endtask

    task automatic op16(input logic [15:0] ia, input logic [15:0] ib, input logic is,
                        output logic [15:0] rs, output logic rc, output logic rov, output int lat);
        a16 = ia; b16 = ib; sub16 = is; s16 = 1'b1;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            s16 = 1'b0;
            if (done16) begin lat = n; break; end
        end
        rs = sum16; rc = c16; rov = ov16;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        got = {busy4, done4, c4, ov4, sum4, busy8, done8, c8, ov8, sum8,
               busy16, done16, c16, ov16};
        checks++;
        if (got !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %h required 00000000", got);
        end
        checks++;
        if (sum16 !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_sum16: got %h required 0000", sum16);
        end
    endtask

    task automatic test_exhaustive_w4();
        logic [3:0] rs;
        logic rc, rov;
        int lat;
        longint es;
        bit ec, eov;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int is = 0; is < 2; is++) begin
                    op4(4'(ia), 4'(ib), 1'(is), rs, rc, rov, lat);
                    ref_op(4, longint'(ia), longint'(ib), 1'(is), es, ec, eov);
                    checks++;
                    if ({rs, rc, rov} !== {4'(es), ec, eov}) begin
                        failures++;
                        $display("[TB] FAIL w4_result a=%h b=%h sub=%0d: got sum=%h c=%b ov=%b required sum=%h c=%b ov=%b",
                                 4'(ia), 4'(ib), is, rs, rc, rov, 4'(es), ec, eov);
                    end
                    checks++;
                    if (lat !== 5) begin
                        failures++;
                        $display("[TB] FAIL w4_latency a=%h b=%h sub=%0d: got %0d required 5",
                                 4'(ia), 4'(ib), is, lat);
                    end
                end
            end
        end
    endtask

    task automatic test_corners_w8();
        logic [7:0] ta [5] = '{8'h0F, 8'hFF, 8'h7F, 8'h05, 8'h80};
        logic [7:0] tb [5] = '{8'h01, 8'h01, 8'h01, 8'h07, 8'h01};
        logic       ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] rs;
        logic rc, rov;
        int lat;
        longint es;
        bit ec, eov;
        for (int i = 0; i < 5; i++) begin
            op8(ta[i], tb[i], ts[i], rs, rc, rov, lat);
            ref_op(8, longint'(ta[i]), longint'(tb[i]), ts[i], es, ec, eov);
            checks++;
            if ({rs, rc, rov} !== {8'(es), ec, eov}) begin
                failures++;
                $display("[TB] FAIL w8_corner%0d: got sum=%h c=%b ov=%b required sum=%h c=%b ov=%b",
                         i, rs, rc, rov, 8'(es), ec, eov);
            end
            checks++;
            if (lat !== 9) begin
                failures++;
                $display("[TB] FAIL w8_corner%0d_latency: got %0d required 9", i, lat);
            end
        end
    endtask

    task automatic test_random_w8();
        logic [7:0] ia, ib, rs;
        logic is, rc, rov;
        int lat;
        longint es;
        bit ec, eov;
        for (int i = 0; i < 60; i++) begin
            ia = 8'($urandom);
            ib = 8'($urandom);
            is = 1'($urandom_range(0, 1));
            op8(ia, ib, is, rs, rc, rov, lat);
            ref_op(8, longint'(ia), longint'(ib), is, es, ec, eov);
            checks++;
            if ({rs, rc, rov, 6'(lat)} !== {8'(es), ec, eov, 6'd9}) begin
                failures++;
                $display("[TB] FAIL w8_random a=%h b=%h sub=%b: got sum=%h c=%b ov=%b lat=%0d required sum=%h c=%b ov=%b lat=9",
                         ia, ib, is, rs, rc, rov, lat, 8'(es), ec, eov);
            end
        end
    endtask

    task automatic test_ignore_start_w8();
        int lat;
        bit busy_mid;
        a8 = 8'h0F; b8 = 8'h01; sub8 = 1'b0; s8 = 1'b1;
        lat = -1;
        busy_mid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            s8 = 1'b0;
            if (n == 2) begin
                s8 = 1'b1; a8 = 8'hAA; b8 = 8'h33; sub8 = 1'b1;
            end
            if (n == 3) busy_mid = busy8;
            if (done8) begin lat = n; break; end
        end
        checks++;
        if (busy_mid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ignore_busy: got %b required 1", busy_mid);
        end
        checks++;
        if ({sum8, c8, ov8} !== {8'h10, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL ignore_result: got sum=%h c=%b ov=%b required sum=10 c=0 ov=0", sum8, c8, ov8);
        end
        checks++;
        if (lat !== 9) begin
            failures++;
            $display("[TB] FAIL ignore_latency: got %0d required 9", lat);
        end
        @(posedge clk); #1;
        checks++;
        if ({busy8, done8} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL ignore_not_queued: got busy=%b done=%b required 0 0", busy8, done8);
        end
    endtask

    task automatic test_abort_w8();
        bit seen_done;
        a8 = 8'h55; b8 = 8'h22; sub8 = 1'b0; s8 = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            @(posedge clk); #1;
            s8 = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({busy8, done8, c8, ov8, sum8} !== 12'h000) begin
            failures++;
            $display("[TB] FAIL abort_outputs: got busy=%b done=%b c=%b ov=%b sum=%h required all 0",
                     busy8, done8, c8, ov8, sum8);
        end
        seen_done = 1'b0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (done8 || busy8) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_no_done: got activity=%b required 0", seen_done);
        end
    endtask

    task automatic test_rst_start_same_edge();
        rst = 1'b1; s8 = 1'b1; a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; s8 = 1'b0;
        checks++;
        if (busy8 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_wins: got busy=%b required 0", busy8);
        end
        @(posedge clk); #1;
        checks++;
        if ({busy8, done8} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL rst_wins_idle: got busy=%b done=%b required 0 0", busy8, done8);
        end
    endtask

    task automatic test_w16_digit4();
        logic [15:0] rs;
        logic rc, rov;
        int lat;
        op16(16'h1234, 16'h0FFF, 1'b0, rs, rc, rov, lat);
        checks++;
        if ({rs, rc, rov} !== {16'h2233, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL w16_fixed: got sum=%h c=%b ov=%b required sum=2233 c=0 ov=0", rs, rc, rov);
        end
        checks++;
        if (lat !== 5) begin
            failures++;
            $display("[TB] FAIL w16_fixed_latency: got %0d required 5", lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ia, ib, rs;
        logic is, rc, rov;
        int lat;
        longint es;
        bit ec, eov;
        for (int i = 0; i < 25; i++) begin
            ia = 16'($urandom);
            ib = 16'($urandom);
            is = 1'($urandom_range(0, 1));
            op16(ia, ib, is, rs, rc, rov, lat);
            ref_op(16, longint'(ia), longint'(ib), is, es, ec, eov);
            checks++;
            if ({rs, rc, rov} !== {16'(es), ec, eov}) begin
                failures++;
                $display("[TB] FAIL b2b_result a=%h b=%h sub=%b: got sum=%h c=%b ov=%b required sum=%h c=%b ov=%b",
                         ia, ib, is, rs, rc, rov, 16'(es), ec, eov);
            end
            checks++;
            if (lat !== 5) begin
                failures++;
                $display("[TB] FAIL b2b_latency a=%h b=%h: got %0d required 5", ia, ib, lat);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        s4 = 1'b0; a4 = '0; b4 = '0; sub4 = 1'b0;
        s8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0;
        s16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_exhaustive_w4();
        test_corners_w8();
        test_random_w8();
        test_ignore_start_w8();
        test_abort_w8();
        test_rst_start_same_edge();
        test_w16_digit4();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
